// File: rtl/oci_dct_pkg.sv
// Shared constants, branch-outcome code values and packer state encoding for the OCI DCT trace path.
package oci_dct_pkg;

    localparam int SLOT_W  = 2;
    localparam int FRAME_W = 36;
    localparam int CNT_W   = 4;
    localparam int BUF_W   = 30;

    localparam logic [SLOT_W-1:0] DCT_NT  = 2'b01;
    localparam logic [SLOT_W-1:0] DCT_TK  = 2'b10;
    localparam logic [SLOT_W-1:0] DCT_EXC = 2'b11;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        STALL
    } dct_state_e;

    // 2'b00 is not a real outcome and never occupies a slot.
    function automatic logic is_legal(input logic [SLOT_W-1:0] code);
        return (code == DCT_NT) || (code == DCT_TK) || (code == DCT_EXC);
    endfunction

endpackage

// File: rtl/oci_dct_idle_timer.sv
// Idle counter for the DCT packer: counts enabled cycles, saturates at TIMEOUT.
// expire is asserted in the cycle whose increment reaches TIMEOUT and held while saturated.
module oci_dct_idle_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && (timer != T_MAX)) begin
            timer <= timer + TW'(1);
        end
    end

    assign expire = (timer == T_MAX) || (enable && (timer == T_PRE));

endmodule

// File: rtl/processador_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT packer: packs 2-bit branch codes into SLOTS-slot frames, emitted on full, flush or idle timeout.
// Optional DCT_PACKER_DROP_CNT_EN adds a saturating drop_count for codes offered while in_ready is low.
module processador_nios2_qsys_0_oci_dct_packer
    import oci_dct_pkg::*;
#(
    parameter int SLOTS   = 15,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dct_valid,
    input  logic [SLOT_W-1:0]  dct_code,
    output logic               in_ready,
    input  logic               flush,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               frame_valid,
    input  logic               frame_ready,
`ifdef DCT_PACKER_DROP_CNT_EN
    output logic [7:0]         drop_count,
`endif
    output logic [FRAME_W-1:0] frame_data
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOTS - 1);

    dct_state_e         state, state_nxt;
    logic               flush_pending, flush_pending_nxt;
    logic               slot_free, accept, flush_req, emit_req, emit;
    logic               timer_en, timer_clr, expire;
    logic [BUF_W-1:0]   upd_buf, buf_nxt;
    logic [CNT_W-1:0]   upd_cnt, cnt_nxt;

    assign slot_free = !frame_valid || frame_ready;
    // Refusing the code that would fill the buffer while the output is busy keeps a full
    // buffer from ever needing to absorb one more code.
    assign in_ready  = (state != STALL) && !((dct_count == LAST) && !slot_free);
    assign accept    = dct_valid && in_ready && is_legal(dct_code);
    assign timer_en  = (dct_count != '0) && !accept;
    assign timer_clr = accept || emit;

    oci_dct_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .expire (expire)
    );

    always_comb begin
        upd_buf = dct_buffer;
        for (int i = 0; i < SLOTS; i++) begin
            if (accept && (dct_count == CNT_W'(i))) begin
                upd_buf[SLOT_W*i +: SLOT_W] = dct_code;
            end
        end
        upd_cnt   = dct_count + CNT_W'(accept);
        flush_req = flush || flush_pending;
        // All three triggers fold into one request, so coincident causes yield one frame.
        emit_req  = (upd_cnt == FULL) || (flush_req && (upd_cnt != '0)) || expire;
        emit      = emit_req && slot_free;
    end

    always_comb begin
        buf_nxt           = upd_buf;
        cnt_nxt           = upd_cnt;
        flush_pending_nxt = flush_req && (upd_cnt != '0);
        state_nxt         = state;
        if (emit) begin
            buf_nxt           = '0;
            cnt_nxt           = '0;
            flush_pending_nxt = 1'b0;
        end
        if (emit_req && !slot_free) begin
            state_nxt = STALL;
        end else if (cnt_nxt == '0) begin
            state_nxt = EMPTY;
        end else begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer    <= '0;
            dct_count     <= '0;
            flush_pending <= 1'b0;
        end else begin
            dct_buffer    <= buf_nxt;
            dct_count     <= cnt_nxt;
            flush_pending <= flush_pending_nxt;
        end
    end

    // frame_data only changes on emit, which needs a free slot, so it is stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (emit) begin
            frame_valid <= 1'b1;
            frame_data  <= {upd_cnt, 2'b00, upd_buf};
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

`ifdef DCT_PACKER_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (dct_valid && !in_ready && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
